// File: rtl/mont_enter.sv
// mont_enter: converts A into the Montgomery domain, M = A*2^WIDTH mod P, by bit-serial modular doubling; MONT_ENTER_IN_REDUCE_EN adds an input reduce step so that A < 2P is accepted
module mont_enter #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] M,
  output logic             done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE   = 2'd0;
`ifdef MONT_ENTER_IN_REDUCE_EN
  localparam logic [1:0] REDUCE = 2'd1;
`endif
  localparam logic [1:0] DOUBLE = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0]       state;
  logic [WIDTH:0]   x;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   x_dbl;
  logic [WIDTH:0]   p_w;
  logic [WIDTH-1:0] p_r;
  logic [CW-1:0]    cnt;
`ifdef MONT_ENTER_IN_REDUCE_EN
  logic [WIDTH:0]   x_red;
`endif
  // one modular doubling step; x < p_r keeps 2x < 2p_r so a single subtract suffices
  always_comb begin
    p_w   = {1'b0, p_r};
    t     = x << 1;
    x_dbl = (t >= p_w) ? t - p_w : t;
`ifdef MONT_ENTER_IN_REDUCE_EN
    x_red = (x >= p_w) ? x - p_w : x;
`endif
  end
  // control FSM with accumulator, step counter and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      p_r   <= '0;
      cnt   <= '0;
      M     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x    <= {1'b0, A};
          p_r  <= P;
          cnt  <= '0;
          busy <= 1'b1;
`ifdef MONT_ENTER_IN_REDUCE_EN
          state <= REDUCE;
`else
          state <= DOUBLE;
`endif
        end
`ifdef MONT_ENTER_IN_REDUCE_EN
        REDUCE: begin
          x     <= x_red;
          state <= DOUBLE;
        end
`endif
        DOUBLE: begin
          x   <= x_dbl;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FINISH;
        end
        FINISH: begin
          M     <= x[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
